// File: rtl/ifetch_unit.sv
// ifetch_unit: owns the PC, issues word fetches under a credit limit and buffers responses for decode.
// Redirects reload the PC, flush the buffer and turn in-flight requests into discards.
module ifetch_unit #(
    parameter int              AW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    output logic          inst_valid,
    output logic [31:0]   inst,
    output logic [AW-1:0] inst_pc,
    input  logic          inst_ready,
    output logic [AW-1:0] pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int SW = CW + 2;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] out_cnt, disc_cnt, buf_cnt;
    logic [CW-1:0] out_rem, disc_rem, out_n, disc_n;
    logic [SW-1:0] credit_used;
    logic [IW-1:0] af_wr, af_rd, bd_wr, bd_rd;
    logic [AW-1:0] af_addr [DEPTH];
    logic [31:0]   bd_inst [DEPTH];
    logic [AW-1:0] bd_pc   [DEPTH];
    logic          grant, resp, stale, fresh, push, pop;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
    endfunction

    // Buffered entries consume credit so the buffer can never overflow.
    assign credit_used = SW'(out_cnt) + SW'(disc_cnt) + SW'(buf_cnt);
    assign imem_req    = !rst && (credit_used < SW'(DEPTH));
    assign imem_addr   = pc;
    assign grant       = imem_req && imem_gnt;
    assign resp        = imem_rvalid && (out_cnt != '0 || disc_cnt != '0);
    assign pop         = inst_valid && inst_ready;
    assign inst_valid  = buf_cnt != '0;
    assign inst        = inst_valid ? bd_inst[bd_rd] : '0;
    assign inst_pc     = inst_valid ? bd_pc[bd_rd] : '0;

    assign out_rem  = out_cnt + CW'(grant) - CW'(fresh);
    assign disc_rem = disc_cnt - CW'(stale);
    assign out_n    = redirect ? '0 : out_rem;
    assign disc_n   = redirect ? disc_rem + out_rem : disc_rem;

    always_ff @(posedge clk) begin
        state <= rst ? RUN : state_n;
    end

    always_comb begin
        state_n = (disc_n != '0) ? DRAIN : RUN;
    end

    // Responses are in order, so while draining every response is a stale one.
    always_comb begin
        stale = resp && state == DRAIN;
        fresh = resp && state == RUN;
        push  = fresh && !redirect;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            out_cnt  <= '0;
            disc_cnt <= '0;
            buf_cnt  <= '0;
            af_wr    <= '0;
            af_rd    <= '0;
            bd_wr    <= '0;
            bd_rd    <= '0;
        end else begin
            pc       <= redirect ? redirect_pc : pc + AW'(grant);
            out_cnt  <= out_n;
            disc_cnt <= disc_n;
            buf_cnt  <= redirect ? '0 : buf_cnt + CW'(push) - CW'(pop);
            af_wr    <= grant ? inc(af_wr) : af_wr;
            af_rd    <= resp ? inc(af_rd) : af_rd;
            bd_wr    <= redirect ? '0 : (push ? inc(bd_wr) : bd_wr);
            bd_rd    <= redirect ? '0 : (pop ? inc(bd_rd) : bd_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (grant)
            af_addr[af_wr] <= pc;
        if (push) begin
            bd_inst[bd_wr] <= imem_rdata;
            bd_pc[bd_wr]   <= af_addr[af_rd];
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed checks of ifetch_unit against an in-order, latency-1 memory model.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst, redirect, imem_gnt, imem_rvalid, inst_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, inst_pc, pc;
    logic [31:0] mq [$];
    logic        mem_hold = 1'b0;
    logic [31:0] exp_addr, exp_pc, base;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .pc(pc)
    );

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory: a grant at one edge is answered during the following cycle unless held.
    task automatic tick();
        logic        g, r;
        logic [31:0] a;
        @(negedge clk);
        g = imem_req && imem_gnt;
        a = imem_addr;
        r = rst;
        @(posedge clk);
        #1;
        if (r) mq.delete();
        else if (g) mq.push_back(a);
        if (!mem_hold && mq.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = f(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic step();
        #1;
        if (inst_valid && inst_ready) begin
            chk("inst_pc", {32'h0, inst_pc}, {32'h0, exp_pc});
            chk("inst", {32'h0, inst}, {32'h0, f(exp_pc)});
            exp_pc++;
        end
        if (imem_req && imem_gnt) begin
            chk("imem_addr", {32'h0, imem_addr}, {32'h0, exp_addr});
            exp_addr++;
        end
        tick();
        redirect = 1'b0;
    endtask

    task automatic go_to(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        step();
        exp_addr = target;
        exp_pc   = target;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        exp_addr = '0; exp_pc = '0;
        repeat (2) step();
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", 64'(inst_pc), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);

        rst = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b1;
        step();
        chk("t1_addr1", 64'(imem_addr), 64'd1);
        chk("t1_valid_early", 64'(inst_valid), 64'd0);
        step();
        chk("t1_valid", 64'(inst_valid), 64'd1);
        chk("t1_first_pc", 64'(inst_pc), 64'd0);
        repeat (20) step();
        chk("t1_progress", 64'(exp_pc >= 10), 64'd1);

        inst_ready = 1'b0;
        repeat (10) step();
        chk("t2_req_drop", 64'(imem_req), 64'd0);
        chk("t2_full", 64'(inst_valid), 64'd1);
        chk("t2_head", 64'(inst_pc), 64'(exp_pc));
        base = exp_pc;
        inst_ready = 1'b1;
        repeat (20) step();
        chk("t2_progress", 64'(exp_pc - base >= 10), 64'd1);

        imem_gnt = 1'b0;
        repeat (6) step();
        chk("t3_drained", 64'(inst_valid), 64'd0);
        go_to(32'd4);
        chk("t3_addr4", 64'(imem_addr), 64'd4);
        mem_hold = 1'b1; imem_gnt = 1'b1;
        repeat (3) step();
        chk("t3_stall_req", 64'(imem_req), 64'd0);
        chk("t3_stall_addr", 64'(imem_addr), 64'd6);
        go_to(32'h100);
        chk("t3_redir_addr", 64'(imem_addr), 64'h100);
        chk("t3_redir_valid", 64'(inst_valid), 64'd0);
        chk("t3_redir_req", 64'(imem_req), 64'd0);
        mem_hold = 1'b0;
        repeat (12) step();
        chk("t3_progress", 64'(exp_pc > 32'h100), 64'd1);

        imem_gnt = 1'b0;
        repeat (6) step();
        go_to(32'd7);
        imem_gnt = 1'b1;
        go_to(32'h40);
        chk("t4_addr", 64'(imem_addr), 64'h40);
        repeat (10) step();
        chk("t4_progress", 64'(exp_pc >= 32'h42), 64'd1);

        imem_gnt = 1'b0;
        repeat (6) step();
        go_to(32'hFFFF_FFFF);
        chk("t5_addr_max", 64'(imem_addr), 64'hFFFF_FFFF);
        imem_gnt = 1'b1;
        step();
        chk("t5_wrap_addr", 64'(imem_addr), 64'd0);
        repeat (10) step();
        chk("t5_progress", 64'(exp_pc >= 2 && exp_pc <= 20), 64'd1);

        inst_ready = 1'b0;
        repeat (4) step();
        chk("t6_pre_valid", 64'(inst_valid), 64'd1);
        rst = 1'b1;
        step();
        chk("t6_valid", 64'(inst_valid), 64'd0);
        chk("t6_req", 64'(imem_req), 64'd0);
        chk("t6_pc", 64'(pc), 64'd0);
        chk("t6_inst", 64'(inst), 64'd0);
        chk("t6_inst_pc", 64'(inst_pc), 64'd0);
        rst = 1'b0; inst_ready = 1'b1;
        exp_addr = '0; exp_pc = '0;
        #1;
        chk("t6_restart_req", 64'(imem_req), 64'd1);
        chk("t6_restart_addr", 64'(imem_addr), 64'd0);
        repeat (10) step();
        chk("t6_progress", 64'(exp_pc >= 5), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Fetch-side consumer of the next-PC logic. Owns the architectural PC register.
- Issues word-addressed fetch requests to instruction memory and buffers the returned instructions.
- Hands instructions to decode over a valid/ready handshake.
- Takes a taken-branch/jump redirect from execute: loads the new PC, flushes buffered instructions and discards stale responses still in flight.

Parameters:
- AW, 32, PC/address width in words; PC advances by 1 per instruction.
- RESET_PC, 0, PC value loaded on reset.
- DEPTH, 2, instruction buffer entries; also the maximum number of in-flight requests.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- redirect  input  1  taken branch/jump from execute, one-cycle pulse.
- redirect_pc  input  AW  target word address, valid when redirect=1.
- imem_req  output  1  fetch request valid.
- imem_addr  output  AW  fetch word address.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response valid; responses are in order, one per grant, latency ≥1 cycle after grant.
- imem_rdata  input  32  instruction word.
- inst_valid  output  1  buffer head valid toward decode.
- inst  output  32  buffer head instruction.
- inst_pc  output  AW  word address of inst.
- inst_ready  input  1  decode accepts head.
- pc  output  AW  next address to be fetched (equals imem_addr).

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0.
  - Buffer count, outstanding count and discard count all zero.
  - Reset mid-operation abandons everything; later imem_rvalid pulses from pre-reset grants are ignored until the outstanding count would have drained.
  - Memory must be reset alongside this block.
- Request issue:
  - imem_req=1 iff !rst && (outstanding + discard + buf_count) < DEPTH.
  - imem_addr=pc, combinational from the register.
  - First request is asserted the cycle after rst falls, with addr=RESET_PC.
- Grant:
  - On imem_req&&imem_gnt: pc<=pc+1 (mod 2^AW; 0xFFFFFFFF wraps to 0), outstanding+=1.
  - The granted address is pushed into an address FIFO of depth DEPTH, used to tag responses with their inst_pc.
- Stall:
  - Without a grant, imem_addr is held stable.
  - Exception: redirect may change imem_addr before a grant. The memory treats that ungranted request as withdrawn.
- Response:
  - On imem_rvalid: pop the address FIFO, outstanding-=1.
  - If discard>0: drop the data and decrement discard.
  - Else: write {rdata, addr} into the buffer tail.
  - A response with outstanding=0 and discard=0 is ignored.
- Buffer:
  - FIFO of DEPTH entries; head drives inst/inst_pc; inst_valid=(buf_count>0).
  - Pop on inst_valid&&inst_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - The credit rule guarantees the buffer never overflows.
  - Data flows from a response into the buffer with 1-cycle latency: rvalid at edge N gives inst_valid at N+1. There is no bypass.
- Redirect, highest priority after rst:
  - pc<=redirect_pc.
  - buf_count<=0, so inst_valid=0 the next cycle.
  - discard<=discard+outstanding, plus 1 if a grant occurs the same cycle; minus 1 if a non-discarded response arrives the same cycle, which is itself dropped.
  - outstanding and the address FIFO move to discard accounting.
  - A pop in the redirect cycle still counts as a transfer; decode squashes it if required.
  - redirect in consecutive cycles: the last target wins; discards accumulate.
- FSM:
  - RUN: discard=0.
  - DRAIN: discard>0; requests still issue under the credit rule.
  - DRAIN -> RUN when the last stale response is dropped.
  - Any state -> DRAIN on redirect with in-flight requests.
  - Any state -> RUN on rst.
- Arithmetic: all PC arithmetic is unsigned AW-bit and wraps. Counters are sized to hold DEPTH exactly.

Test Plan:
- Reset, then gnt=1 every cycle, rvalid 1 cycle after gnt, inst_ready=1 → imem_addr 0,1,2,…; inst_pc 0,1,2,… with matching rdata; inst_valid first high 2 cycles after first grant.
- inst_ready=0 for 10 cycles with gnt/rvalid always 1 → buffer fills to 2; imem_req drops once 2 are buffered/in flight; release ready → inst_pc continues 0,1,2 in order, no loss, no duplication.
- Two requests outstanding (addr 4,5), redirect to 0x100 → next imem_addr=0x100; both late responses dropped; first inst_valid carries inst_pc=0x100.
- redirect to 0x40 in the same cycle as a grant of addr 7 → the response for 7 is discarded; pc continues 0x40, 0x41.
- redirect_pc=0xFFFFFFFF, grants → imem_addr 0xFFFFFFFF then 0x00000000; inst_pc follows.
- rst asserted mid-stream with a buffer entry valid → next cycle inst_valid=0, imem_req=0, pc=RESET_PC; after release, fetch restarts at RESET_PC.
